// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
// Contents: ctrl_state_e (RUN/STALL/FLUSH/FREEZE), sb_entry_t (scoreboard entry),
// XZR_REG (register index that never creates a hazard).
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FLUSH  = 2'd2,
    FREEZE = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       is_load;
    logic       flags_we;
  } sb_entry_t;

  localparam logic [4:0] XZR_REG = 5'd31;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - ID-stage decode / pipeline-enable bundle
// master: decoder/datapath side, drives decoded ID bits, ex_br_taken, mem_busy
//         and receives the register enables.
// slave:  hazard controller side.
interface pipeline_hazard_ctrl_if;
  logic       id_valid;
  logic [4:0] id_rn;
  logic [4:0] id_rm;
  logic       id_use_rn;
  logic       id_use_rm;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_is_load;
  logic       id_flags_we;
  logic       id_uses_flags;
  logic       ex_br_taken;
  logic       mem_busy;
  logic       pc_we;
  logic       ifid_we;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       exmem_we;

  modport master (
    output id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd,
           id_regwrite, id_is_load, id_flags_we, id_uses_flags,
           ex_br_taken, mem_busy,
    input  pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we
  );

  modport slave (
    input  id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd,
           id_regwrite, id_is_load, id_flags_we, id_uses_flags,
           ex_br_taken, mem_busy,
    output pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - two-entry EX/MEM instruction scoreboard
// Ports: clk, reset (async active-low clear), hold (freeze both entries),
// bubble (ex <= invalid, mem <= ex), shift (ex <= din, mem <= ex),
// din (entry for the ID instruction), ex / mem (current entries).
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      hold,
  input  logic      bubble,
  input  logic      shift,
  input  sb_entry_t din,
  output sb_entry_t ex,
  output sb_entry_t mem
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex  <= '0;
      mem <= '0;
    end else if (hold) begin
      ex  <= ex;
      mem <= mem;
    end else if (bubble) begin
      ex  <= '0;
      mem <= ex;
    end else if (shift) begin
      ex  <= din;
      mem <= ex;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use/flag hazard, branch flush and memory freeze control
// Ports: clk, reset (async active-low), bus (slave modport: decoded ID bits,
// ex_br_taken, mem_busy in; pc_we/ifid_we/ifid_flush/idex_bubble/exmem_we out),
// state (action taken at last edge), stall_cnt / flush_cnt (saturating).
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int         CNT_W = 16,
  parameter logic [4:0] XZR   = hazard_pkg::XZR_REG
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  bus,
  output ctrl_state_e            state,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       flush_cnt
);

  sb_entry_t   ex_e;
  sb_entry_t   mem_e;
  sb_entry_t   din;
  ctrl_state_e act;
  logic        rn_hit;
  logic        rm_hit;
  logic        load_use;
  logic        flag_use;
  logic        hz;

  assign din = '{valid:    bus.id_valid,
                 rd:       bus.id_rd,
                 regwrite: bus.id_regwrite,
                 is_load:  bus.id_is_load,
                 flags_we: bus.id_flags_we};

  // Only a load in EX needs a stall; ALU results and MEM-stage values are forwarded.
  assign rn_hit   = bus.id_use_rn && (bus.id_rn == ex_e.rd) && (bus.id_rn != XZR);
  assign rm_hit   = bus.id_use_rm && (bus.id_rm == ex_e.rd) && (bus.id_rm != XZR);
  assign load_use = ex_e.valid && ex_e.is_load && ex_e.regwrite && (rn_hit || rm_hit);
  assign flag_use = ex_e.valid && ex_e.flags_we && bus.id_uses_flags;
  assign hz       = bus.id_valid && (load_use || flag_use);

  always_comb begin
    act = RUN;
    if (bus.mem_busy)         act = FREEZE;
    else if (bus.ex_br_taken) act = FLUSH;
    else if (hz)              act = STALL;
  end

  always_comb begin
    bus.pc_we       = 1'b1;
    bus.ifid_we     = 1'b1;
    bus.ifid_flush  = 1'b0;
    bus.idex_bubble = 1'b0;
    bus.exmem_we    = 1'b1;
    if (!reset) begin
      // Hold the front end with NOPs loaded while in reset, whatever the inputs.
      bus.pc_we       = 1'b0;
      bus.ifid_we     = 1'b0;
      bus.ifid_flush  = 1'b1;
      bus.idex_bubble = 1'b1;
      bus.exmem_we    = 1'b0;
    end else begin
      case (act)
        FREEZE: begin
          bus.pc_we    = 1'b0;
          bus.ifid_we  = 1'b0;
          bus.exmem_we = 1'b0;
        end
        FLUSH: begin
          bus.ifid_flush  = 1'b1;
          bus.idex_bubble = 1'b1;
        end
        STALL: begin
          bus.pc_we       = 1'b0;
          bus.ifid_we     = 1'b0;
          bus.idex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  hazard_scoreboard u_sb (
    .clk    (clk),
    .reset  (reset),
    .hold   (act == FREEZE),
    .bubble ((act == FLUSH) || (act == STALL)),
    .shift  (act == RUN),
    .din    (din),
    .ex     (ex_e),
    .mem    (mem_e)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= act;
      if ((act == STALL) && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
      if ((act == FLUSH) && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  import hazard_pkg::*;

  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic clk = 1'b0;
  logic rst_n;
  ctrl_state_e st;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (bus.slave),
    .state     (st),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst_n;
    bit valid;
    int rn;
    int rm;
    bit use_rn;
    bit use_rm;
    int rd;
    bit regwrite;
    bit is_load;
    bit flags_we;
    bit uses_flags;
    bit br;
    bit busy;
  } stim_t;

  typedef struct {
    bit pc_we;
    bit ifid_we;
    bit ifid_flush;
    bit idex_bubble;
    bit exmem_we;
    int st;
    int sc;
    int fc;
  } exp_t;

  // Reference: the instruction sitting in EX and in MEM, as the pipeline sees them.
  typedef struct {
    bit valid;
    int rd;
    bit writes;
    bit load;
    bit sets_flags;
  } instr_t;

  instr_t in_ex, in_mem;
  int     m_state, m_sc, m_fc;
  exp_t   expq[$];
  int     n_chk = 0;
  int     n_fail = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit reads_reg(stim_t s, int r);
    if (r == 31) return 1'b0;
    return (s.use_rn && s.rn == r) || (s.use_rm && s.rm == r);
  endfunction

  task automatic drive(stim_t s);
    exp_t   e;
    instr_t nop;
    bit     ld, fl, hz;
    int     a;
    nop = '{0, 0, 0, 0, 0};
    @(posedge clk);
    #1;
    rst_n             = s.rst_n;
    bus.id_valid      = s.valid;
    bus.id_rn         = 5'(s.rn);
    bus.id_rm         = 5'(s.rm);
    bus.id_use_rn     = s.use_rn;
    bus.id_use_rm     = s.use_rm;
    bus.id_rd         = 5'(s.rd);
    bus.id_regwrite   = s.regwrite;
    bus.id_is_load    = s.is_load;
    bus.id_flags_we   = s.flags_we;
    bus.id_uses_flags = s.uses_flags;
    bus.ex_br_taken   = s.br;
    bus.mem_busy      = s.busy;
    if (!s.rst_n) begin
      in_ex = nop; in_mem = nop; m_state = 0; m_sc = 0; m_fc = 0;
    end
    ld = in_ex.valid && in_ex.load && in_ex.writes && reads_reg(s, in_ex.rd);
    fl = in_ex.valid && in_ex.sets_flags && s.uses_flags;
    hz = s.valid && (ld || fl);
    a  = s.busy ? 3 : s.br ? 2 : hz ? 1 : 0;
    if (!s.rst_n)    e = '{0, 0, 1, 1, 0, 0, 0, 0};
    else if (a == 3) e = '{0, 0, 0, 0, 0, 0, 0, 0};
    else if (a == 2) e = '{1, 1, 1, 1, 1, 0, 0, 0};
    else if (a == 1) e = '{0, 0, 0, 1, 1, 0, 0, 0};
    else             e = '{1, 1, 0, 0, 1, 0, 0, 0};
    e.st = m_state; e.sc = m_sc; e.fc = m_fc;
    expq.push_back(e);
    if (s.rst_n) begin
      m_state = a;
      if (a == 1 || a == 2) begin
        in_mem = in_ex; in_ex = nop;
        if (a == 1 && m_sc < CMAX) m_sc++;
        if (a == 2 && m_fc < CMAX) m_fc++;
      end else if (a == 0) begin
        in_mem = in_ex;
        in_ex  = '{s.valid, s.rd, s.regwrite, s.is_load, s.flags_we};
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("pc_we", 32'(bus.pc_we), 32'(e.pc_we));
      chk("ifid_we", 32'(bus.ifid_we), 32'(e.ifid_we));
      chk("ifid_flush", 32'(bus.ifid_flush), 32'(e.ifid_flush));
      chk("idex_bubble", 32'(bus.idex_bubble), 32'(e.idex_bubble));
      chk("exmem_we", 32'(bus.exmem_we), 32'(e.exmem_we));
      chk("state", 32'(st), 32'(e.st));
      chk("stall_cnt", 32'(stall_cnt), 32'(e.sc));
      chk("flush_cnt", 32'(flush_cnt), 32'(e.fc));
    end
  end

  function automatic stim_t idle();
    return '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  endfunction

  function automatic stim_t ldur(int rd);
    stim_t s = idle();
    s.valid = 1; s.rd = rd; s.regwrite = 1; s.is_load = 1;
    return s;
  endfunction

  function automatic stim_t rd_rn(int r);
    stim_t s = idle();
    s.valid = 1; s.rn = r; s.use_rn = 1; s.rd = 10; s.regwrite = 1;
    return s;
  endfunction

  function automatic stim_t rd_rm(int r);
    stim_t s = idle();
    s.valid = 1; s.rm = r; s.use_rm = 1; s.rd = 11; s.regwrite = 1;
    return s;
  endfunction

  function automatic stim_t blt();
    stim_t s = idle();
    s.valid = 1; s.uses_flags = 1;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    int regs[4] = '{1, 2, 3, 31};
    s.rst_n      = ($urandom_range(0, 499) != 0);
    s.valid      = ($urandom_range(0, 9) != 0);
    s.rn         = regs[$urandom_range(0, 3)];
    s.rm         = regs[$urandom_range(0, 3)];
    s.use_rn     = $urandom_range(0, 1);
    s.use_rm     = $urandom_range(0, 1);
    s.rd         = regs[$urandom_range(0, 3)];
    s.regwrite   = ($urandom_range(0, 4) != 0);
    s.is_load    = ($urandom_range(0, 4) < 2);
    s.flags_we   = ($urandom_range(0, 4) == 0);
    s.uses_flags = ($urandom_range(0, 4) == 0);
    s.br         = ($urandom_range(0, 9) == 0);
    s.busy       = ($urandom_range(0, 6) == 0);
    return s;
  endfunction

  initial begin
    stim_t s;
    rst_n = 1'b0;
    bus.id_valid = 0; bus.id_rn = 0; bus.id_rm = 0; bus.id_use_rn = 0;
    bus.id_use_rm = 0; bus.id_rd = 0; bus.id_regwrite = 0; bus.id_is_load = 0;
    bus.id_flags_we = 0; bus.id_uses_flags = 0; bus.ex_br_taken = 0; bus.mem_busy = 0;
    in_ex = '{0, 0, 0, 0, 0}; in_mem = in_ex; m_state = 0; m_sc = 0; m_fc = 0;

    s = idle(); s.rst_n = 0; s.busy = 1; s.br = 1;
    drive(s); drive(s);
    drive(idle());
    // Load-use on Rn: one stall, then run.
    drive(ldur(1)); drive(rd_rn(1)); drive(rd_rn(1));
    // XZR immunity.
    drive(ldur(31)); drive(rd_rn(31));
    // Flags: SUBS then B.LT stalls once; ADDI then B.LT does not.
    s = idle(); s.valid = 1; s.rd = 2; s.regwrite = 1; s.flags_we = 1;
    drive(s); drive(blt()); drive(blt());
    s = idle(); s.valid = 1; s.rd = 3; s.regwrite = 1;
    drive(s); drive(blt());
    // Taken branch together with load-use on Rm gives FLUSH only.
    drive(ldur(4)); s = rd_rm(4); s.br = 1; drive(s);
    // Memory freeze held 3 cycles over a pending load-use, then one stall.
    drive(ldur(5)); s = rd_rn(5); s.busy = 1;
    drive(s); drive(s); drive(s);
    drive(rd_rn(5)); drive(rd_rn(5));
    // Reset asserted during a stall.
    drive(ldur(6)); drive(rd_rn(6)); s = rd_rn(6); s.rst_n = 0; drive(s);
    drive(idle());
    // Saturation: 20 back-to-back load-use stalls.
    for (int i = 0; i < 20; i++) begin
      drive(ldur(7)); drive(rd_rn(7));
    end
    for (int i = 0; i < 3000; i++) drive(rnd());
    @(posedge clk);
    @(posedge clk);
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
